// File: rtl/hazard_fwd_unit_pkg.sv
// Shared CPU pipeline definitions: forward-mux select codes, hazard FSM states
// and default geometry for the hazard/forwarding unit.
package hazard_fwd_unit_pkg;

  localparam int NPORT_DEF  = 2;
  localparam int AW_DEF     = 5;
  localparam int MD_LAT_DEF = 4;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF   = 2'b00;  // register file
  localparam fwd_sel_t FWD_NEAR = 2'b01;  // nearest producer
  localparam fwd_sel_t FWD_FAR  = 2'b10;  // second-nearest producer

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD1   = 2'd1,
    ST_MD_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_unit_fwd_match.sv
// Single-port producer/consumer compare: picks the nearest writing producer whose
// nonzero destination matches the consumer address, else the farther one.
module fwd_match
  import hazard_fwd_unit_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] src_addr,
  input  logic          near_we,
  input  logic [AW-1:0] near_addr,
  input  logic          far_we,
  input  logic [AW-1:0] far_addr,
  output fwd_sel_t      sel
);

  always_comb begin
    sel = FWD_RF;
    if (near_we && (near_addr != '0) && (near_addr == src_addr)) begin
      sel = FWD_NEAR;
    end else if (far_we && (far_addr != '0) && (far_addr == src_addr)) begin
      sel = FWD_FAR;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard detection and operand forwarding: combinational forward selects,
// stall/bubble generation for load-use, branch-in-ID and multiply/divide hazards.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int NPORT  = NPORT_DEF,
  parameter int AW     = AW_DEF,
  parameter int MD_LAT = MD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NPORT*AW-1:0]  id_src_addr,
  input  logic [NPORT-1:0]     id_src_used,
  input  logic                 id_is_branch,
  input  logic                 id_md_use,
  input  logic [NPORT*AW-1:0]  ex_src_addr,
  input  logic                 idex_regwrite,
  input  logic                 idex_memread,
  input  logic                 idex_md_start,
  input  logic [AW-1:0]        idex_waddr,
  input  logic                 exmem_regwrite,
  input  logic                 exmem_memread,
  input  logic [AW-1:0]        exmem_waddr,
  input  logic                 memwb_regwrite,
  input  logic [AW-1:0]        memwb_waddr,
  output logic [2*NPORT-1:0]   fwd_id_sel,
  output logic [2*NPORT-1:0]   fwd_ex_sel,
  output logic                 fwd_mem,
  output logic                 stall,
  output logic                 bubble,
  output logic [31:0]          stall_count
);

  localparam int CW = $clog2(MD_LAT);
  localparam logic [CW-1:0] MD_LOAD = CW'(MD_LAT - 1);
  localparam int SD_PORT = (NPORT > 1) ? 1 : 0;

  hz_state_t     state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic [31:0]   stall_count_q, stall_count_d;
  logic [AW-1:0] store_src_q, store_src_d;

  logic [NPORT-1:0] idex_hit, exmem_hit;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    fwd_sel_t id_sel, ex_sel;

    fwd_match #(.AW(AW)) u_id_match (
      .src_addr  (id_src_addr[p*AW +: AW]),
      .near_we   (exmem_regwrite),
      .near_addr (exmem_waddr),
      .far_we    (memwb_regwrite),
      .far_addr  (memwb_waddr),
      .sel       (id_sel)
    );

    fwd_match #(.AW(AW)) u_ex_match (
      .src_addr  (ex_src_addr[p*AW +: AW]),
      .near_we   (idex_regwrite),
      .near_addr (idex_waddr),
      .far_we    (exmem_regwrite),
      .far_addr  (exmem_waddr),
      .sel       (ex_sel)
    );

    assign fwd_id_sel[2*p +: 2] = rst ? FWD_RF : id_sel;
    assign fwd_ex_sel[2*p +: 2] = rst ? FWD_RF : ex_sel;

    assign idex_hit[p]  = id_src_used[p] && idex_regwrite && (idex_waddr != '0)
                          && (idex_waddr == id_src_addr[p*AW +: AW]);
    assign exmem_hit[p] = id_src_used[p] && exmem_regwrite && (exmem_waddr != '0)
                          && (exmem_waddr == id_src_addr[p*AW +: AW]);
  end

  // Store data in MEM came from EX port 1 one cycle earlier.
  assign store_src_d = ex_src_addr[SD_PORT*AW +: AW];
  assign fwd_mem = !rst && memwb_regwrite && (memwb_waddr != '0)
                   && (memwb_waddr == store_src_q);

  logic       idex_any, exmem_any;
  logic [1:0] need_n;

  always_comb begin
    idex_any  = |idex_hit;
    exmem_any = |exmem_hit;
    need_n    = 2'd0;
    if (id_is_branch && idex_any && idex_memread) begin
      need_n = 2'd2;
    end else if ((idex_any && idex_memread) || (id_is_branch && idex_any)
                 || (id_is_branch && exmem_any && exmem_memread)) begin
      need_n = 2'd1;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    stall   = 1'b0;
    if (!rst && !flush) begin
      unique case (state_q)
        ST_RUN: begin
          if (need_n != 2'd0) begin
            stall   = 1'b1;
            state_d = (need_n == 2'd2) ? ST_HOLD1 : ST_RUN;
          end else if (id_md_use && (md_cnt_q != '0)) begin
            stall   = 1'b1;
            state_d = ST_MD_WAIT;
          end
        end
        ST_HOLD1: begin
          stall   = 1'b1;
          state_d = ST_RUN;
        end
        ST_MD_WAIT: begin
          stall   = 1'b1;
          state_d = (md_cnt_q <= CW'(1)) ? ST_RUN : ST_MD_WAIT;
        end
        default: begin
          stall   = 1'b0;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign bubble = stall;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (idex_md_start) begin
      md_cnt_d = MD_LOAD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      md_cnt_q      <= '0;
      stall_count_q <= '0;
      store_src_q   <= '0;
    end else begin
      state_q       <= state_d;
      md_cnt_q      <= md_cnt_d;
      stall_count_q <= stall_count_d;
      store_src_q   <= store_src_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit with hand-computed expectations.
module tb_hazard_fwd_unit;

  localparam int NPORT = 2;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NPORT*AW-1:0] id_src_addr;
  logic [NPORT-1:0]  id_src_used;
  logic              id_is_branch;
  logic              id_md_use;
  logic [NPORT*AW-1:0] ex_src_addr;
  logic              idex_regwrite, idex_memread, idex_md_start;
  logic [AW-1:0]     idex_waddr;
  logic              exmem_regwrite, exmem_memread;
  logic [AW-1:0]     exmem_waddr;
  logic              memwb_regwrite;
  logic [AW-1:0]     memwb_waddr;
  logic [2*NPORT-1:0] fwd_id_sel, fwd_ex_sel;
  logic              fwd_mem, stall, bubble;
  logic [31:0]       stall_count;

  int checks = 0;
  int errors = 0;
  int nstall;

  hazard_fwd_unit #(.NPORT(NPORT), .AW(AW), .MD_LAT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_is_branch(id_is_branch), .id_md_use(id_md_use),
    .ex_src_addr(ex_src_addr),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .idex_md_start(idex_md_start), .idex_waddr(idex_waddr),
    .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
    .exmem_waddr(exmem_waddr),
    .memwb_regwrite(memwb_regwrite), .memwb_waddr(memwb_waddr),
    .fwd_id_sel(fwd_id_sel), .fwd_ex_sel(fwd_ex_sel), .fwd_mem(fwd_mem),
    .stall(stall), .bubble(bubble), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    flush = 0; id_src_addr = '0; id_src_used = '0; id_is_branch = 0; id_md_use = 0;
    ex_src_addr = '0; idex_regwrite = 0; idex_memread = 0; idex_md_start = 0;
    idex_waddr = '0; exmem_regwrite = 0; exmem_memread = 0; exmem_waddr = '0;
    memwb_regwrite = 0; memwb_waddr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    set_idle();
    rst = 1;
    tick(); tick();

    // Reset: forwarding candidates present but everything must read zero.
    exmem_regwrite = 1; exmem_waddr = 5'd3; id_src_addr[0 +: AW] = 5'd3;
    idex_regwrite = 1; idex_waddr = 5'd3; ex_src_addr[0 +: AW] = 5'd3;
    idex_memread = 1; id_src_used = 2'b01;
    settle();
    check_val("rst_id_sel", 32'(fwd_id_sel), 32'h0);
    check_val("rst_ex_sel", 32'(fwd_ex_sel), 32'h0);
    check_val("rst_stall", 32'(stall), 32'h0);
    check_val("rst_bubble", 32'(bubble), 32'h0);
    check_val("rst_fwd_mem", 32'(fwd_mem), 32'h0);
    check_val("rst_count", stall_count, 32'h0);
    set_idle();
    rst = 0;
    tick();

    // ID forwarding priority and r0 exclusion.
    exmem_regwrite = 1; exmem_waddr = 5'd3; memwb_regwrite = 1; memwb_waddr = 5'd3;
    id_src_addr = {5'd0, 5'd3};
    settle(); check_val("id_near", 32'(fwd_id_sel), 32'b0001);
    exmem_waddr = 5'd0; memwb_waddr = 5'd0; id_src_addr = {5'd0, 5'd0};
    settle(); check_val("id_r0", 32'(fwd_id_sel), 32'b0000);
    exmem_waddr = 5'd0; memwb_waddr = 5'd3; id_src_addr = {5'd0, 5'd3};
    settle(); check_val("id_far", 32'(fwd_id_sel), 32'b0010);
    exmem_waddr = 5'd5; memwb_waddr = 5'd7; id_src_addr = {5'd7, 5'd5};
    settle(); check_val("id_both_ports", 32'(fwd_id_sel), 32'b1001);
    id_src_addr = {5'd5, 5'd3};
    settle(); check_val("id_port1_only", 32'(fwd_id_sel), 32'b0100);
    set_idle();

    // EX forwarding.
    idex_regwrite = 1; idex_waddr = 5'd4; exmem_regwrite = 1; exmem_waddr = 5'd6;
    ex_src_addr = {5'd6, 5'd4};
    settle(); check_val("ex_sel_mix", 32'(fwd_ex_sel), 32'b1001);
    exmem_waddr = 5'd4; ex_src_addr = {5'd4, 5'd4};
    settle(); check_val("ex_near_prio", 32'(fwd_ex_sel), 32'b0101);
    idex_regwrite = 0;
    settle(); check_val("ex_far", 32'(fwd_ex_sel), 32'b1010);
    set_idle();

    // Store-data forward uses EX port 1 latched one cycle earlier.
    ex_src_addr = {5'd9, 5'd0};
    tick();
    ex_src_addr = '0; memwb_regwrite = 1; memwb_waddr = 5'd9;
    settle(); check_val("fwd_mem_hit", 32'(fwd_mem), 32'h1);
    memwb_regwrite = 0;
    settle(); check_val("fwd_mem_nowe", 32'(fwd_mem), 32'h0);
    memwb_regwrite = 1;
    tick();
    check_val("fwd_mem_expired", 32'(fwd_mem), 32'h0);
    set_idle();

    // Load-use: unused port must not stall; used port stalls one cycle.
    idex_regwrite = 1; idex_memread = 1; idex_waddr = 5'd8;
    id_src_addr = {5'd0, 5'd8}; id_src_used = 2'b10;
    settle(); check_val("lu_unused", 32'(stall), 32'h0);
    id_src_used = 2'b01;
    settle(); check_val("lu_stall", 32'(stall), 32'h1);
    check_val("lu_bubble", 32'(bubble), 32'h1);
    tick();
    set_idle();
    settle(); check_val("lu_release", 32'(stall), 32'h0);
    check_val("lu_count", stall_count, 32'd1);

    // Branch on a load result: two stall cycles, HOLD1 ignores inputs.
    id_is_branch = 1; idex_regwrite = 1; idex_memread = 1; idex_waddr = 5'd9;
    id_src_addr = {5'd9, 5'd0}; id_src_used = 2'b10;
    settle(); check_val("br_ld_c1", 32'(stall), 32'h1);
    tick();
    set_idle();
    settle(); check_val("br_ld_c2", 32'(stall), 32'h1);
    tick();
    settle(); check_val("br_ld_run", 32'(stall), 32'h0);
    check_val("br_ld_count", stall_count, 32'd3);

    // Branch on ALU result in ID/EX, then on load in EX/MEM: one cycle each.
    id_is_branch = 1; idex_regwrite = 1; idex_waddr = 5'd2;
    id_src_addr = {5'd0, 5'd2}; id_src_used = 2'b01;
    settle(); check_val("br_alu", 32'(stall), 32'h1);
    tick();
    set_idle();
    id_is_branch = 1; exmem_regwrite = 1; exmem_memread = 1; exmem_waddr = 5'd2;
    id_src_addr = {5'd0, 5'd2}; id_src_used = 2'b01;
    settle(); check_val("br_exmem_ld", 32'(stall), 32'h1);
    tick();
    id_is_branch = 0;
    settle(); check_val("nobr_exmem_ld", 32'(stall), 32'h0);
    check_val("br_count", stall_count, 32'd5);
    set_idle();

    // Multiply/divide: MD_LAT=4 gives three stall cycles.
    idex_md_start = 1;
    tick();
    idex_md_start = 0; id_md_use = 1;
    nstall = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (stall) nstall++;
      tick();
    end
    check_val("md_stalls", 32'(nstall), 32'd3);
    check_val("md_count", stall_count, 32'd8);
    set_idle();

    // Flush during HOLD1 and during a RUN-state load-use hazard.
    id_is_branch = 1; idex_regwrite = 1; idex_memread = 1; idex_waddr = 5'd9;
    id_src_addr = {5'd9, 5'd0}; id_src_used = 2'b10;
    tick();
    set_idle(); flush = 1;
    settle(); check_val("flush_hold1", 32'(stall), 32'h0);
    check_val("flush_bubble", 32'(bubble), 32'h0);
    tick();
    flush = 0;
    settle(); check_val("flush_run", 32'(stall), 32'h0);
    check_val("flush_count", stall_count, 32'd9);
    idex_regwrite = 1; idex_memread = 1; idex_waddr = 5'd8;
    id_src_addr = {5'd0, 5'd8}; id_src_used = 2'b01; flush = 1;
    settle(); check_val("flush_lu", 32'(stall), 32'h0);
    set_idle();

    // Reset while waiting on multiply/divide.
    idex_md_start = 1;
    tick();
    idex_md_start = 0; id_md_use = 1;
    tick();
    rst = 1;
    settle(); check_val("rst_md_stall", 32'(stall), 32'h0);
    tick();
    rst = 0;
    settle(); check_val("rst_md_counter", 32'(stall), 32'h0);
    check_val("rst_md_count", stall_count, 32'h0);
    set_idle();

    // Saturation: preload counter near the top under a constant stall.
    idex_regwrite = 1; idex_memread = 1; idex_waddr = 5'd8;
    id_src_addr = {5'd0, 5'd8}; id_src_used = 2'b01;
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    tick();
    check_val("sat_reach", stall_count, 32'hFFFF_FFFF);
    tick();
    check_val("sat_hold", stall_count, 32'hFFFF_FFFF);
    set_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
